// File: rtl/sdram_req_sched.sv
// sdram_req_sched: request FIFO plus issue scheduler in front of an SDRAM
// command state machine. Requests are queued, issued one at a time with a
// single-cycle go_o pulse, and popped when the controller acknowledges.
// Optional periodic refresh scheduling is compiled in when the macro
// SDRAM_SCHED_REF_EN is defined; the default build has no refresh logic.
module sdram_req_sched #(
  parameter int unsigned DEPTH_p        = 4,
  parameter int unsigned ADDR_W_p       = 24,
  parameter int unsigned DATA_W_p       = 16,
  parameter int unsigned REF_INTERVAL_p = 1040
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [ADDR_W_p-1:0]        req_addr_i,
  input  logic [DATA_W_p-1:0]        req_wdata_i,
  output logic                       go_o,
  output logic                       rw_en_o,
  output logic [ADDR_W_p-1:0]        addr_o,
  output logic [DATA_W_p-1:0]        wdata_o,
  input  logic                       cmd_ack_i,
  output logic                       ref_req_o,
  input  logic                       ref_ack_i,
  output logic [$clog2(DEPTH_p):0]   level_o
);

  localparam int unsigned PTR_W = (DEPTH_p > 1) ? $clog2(DEPTH_p) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH_p) + 1;

  // Elaboration guard: pointer wrap relies on a power-of-two depth.
  if (DEPTH_p < 2 || (DEPTH_p & (DEPTH_p - 1)) != 0) begin : g_depth_chk
    $error("sdram_req_sched: DEPTH_p must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_REFRESH = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_go;
  logic                  r_rw_en;
  logic [ADDR_W_p-1:0]   r_addr;
  logic [DATA_W_p-1:0]   r_wdata;

  logic                  r_mem_we    [DEPTH_p];
  logic [ADDR_W_p-1:0]   r_mem_addr  [DEPTH_p];
  logic [DATA_W_p-1:0]   r_mem_wdata [DEPTH_p];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_not_empty;
  logic                  w_ref_pending;
  logic                  w_ref_ack;

  // FIFO handshake: no bypass, a full FIFO refuses even when popping.
  assign req_ready_o = (r_level != LVL_W'(DEPTH_p));
  assign w_push      = req_valid_i && req_ready_o;
  assign w_pop       = (r_state == ST_WAIT) && cmd_ack_i;
  assign w_not_empty = (r_level != LVL_W'(0));

  assign go_o    = r_go;
  assign rw_en_o = r_rw_en;
  assign addr_o  = r_addr;
  assign wdata_o = r_wdata;
  assign level_o = r_level;

  // Request storage; contents need no reset since level qualifies them.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_we[r_wr_ptr]    <= req_we_i;
      r_mem_addr[r_wr_ptr]  <= req_addr_i;
      r_mem_wdata[r_wr_ptr] <= req_wdata_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef SDRAM_SCHED_REF_EN
  localparam int unsigned REF_CNT_W = (REF_INTERVAL_p > 2) ? $clog2(REF_INTERVAL_p) : 1;

  logic [REF_CNT_W-1:0] r_ref_cnt;
  logic                 r_ref_pending;
  logic                 r_ref_req;
  logic                 w_ref_wrap;

  assign w_ref_wrap    = (r_ref_cnt == REF_CNT_W'(REF_INTERVAL_p - 1));
  assign w_ref_pending = r_ref_pending;
  assign w_ref_ack     = ref_ack_i;
  assign ref_req_o     = r_ref_req;

  // Free-running refresh interval counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ref_cnt <= '0;
    end else if (w_ref_wrap) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + REF_CNT_W'(1);
    end
  end

  // Pending flag: a new interval wins over a same-cycle completion; misses are not queued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ref_pending <= 1'b0;
    end else if (w_ref_wrap) begin
      r_ref_pending <= 1'b1;
    end else if (r_state == ST_REFRESH && ref_ack_i) begin
      r_ref_pending <= 1'b0;
    end
  end

  // Refresh request held high for the whole REFRESH state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ref_req <= 1'b0;
    end else if (r_state == ST_IDLE && r_ref_pending) begin
      r_ref_req <= 1'b1;
    end else if (r_state == ST_REFRESH && ref_ack_i) begin
      r_ref_req <= 1'b0;
    end
  end
`else
  logic w_unused_ref_ack;

  assign w_unused_ref_ack = ref_ack_i;
  assign w_ref_pending    = 1'b0;
  assign w_ref_ack        = 1'b0;
  assign ref_req_o        = 1'b0;
`endif

  // Scheduler FSM: refresh has priority in IDLE but never preempts a command.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_go    <= 1'b0;
      r_rw_en <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_go <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ref_pending) begin
            r_state <= ST_REFRESH;
          end else if (w_not_empty) begin
            r_state <= ST_ISSUE;
            r_go    <= 1'b1;
            r_rw_en <= r_mem_we[r_rd_ptr];
            r_addr  <= r_mem_addr[r_rd_ptr];
            r_wdata <= r_mem_wdata[r_rd_ptr];
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cmd_ack_i) begin
            r_state <= ST_IDLE;
          end
        end
        ST_REFRESH: begin
          if (w_ref_ack) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_req_sched.sv
// Testbench for sdram_req_sched: randomized traffic checked cycle by cycle
// against a queue-based reference model, plus directed reset scenarios.
// Follows SDRAM_SCHED_REF_EN the same way as the design.
module tb_sdram_req_sched;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned AW     = 24;
  localparam int unsigned DW     = 16;
  localparam int unsigned REF_IV = 16;
  localparam int unsigned LW     = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          go_o;
  logic          rw_en_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic          cmd_ack_i;
  logic          ref_req_o;
  logic          ref_ack_i;
  logic [LW-1:0] level_o;

  sdram_req_sched #(
    .DEPTH_p        (DEPTH),
    .ADDR_W_p       (AW),
    .DATA_W_p       (DW),
    .REF_INTERVAL_p (REF_IV)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .go_o        (go_o),
    .rw_en_o     (rw_en_o),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .cmd_ack_i   (cmd_ack_i),
    .ref_req_o   (ref_req_o),
    .ref_ack_i   (ref_ack_i),
    .level_o     (level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  // Reference model: queue of accepted requests plus a few behavioural flags.
  req_t m_q[$];
  bit   m_go;       // go pulse expected this cycle
  bit   m_wait;     // command issued, acknowledge outstanding
  bit   m_ref_req;  // refresh being requested this cycle
  bit   m_pend;     // refresh interval elapsed, not yet serviced
  int   m_cnt;      // cycles since the interval last restarted

  int n_checks;
  int n_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_go      = 1'b0;
    m_wait    = 1'b0;
    m_ref_req = 1'b0;
    m_pend    = 1'b0;
    m_cnt     = 0;
  endtask

  task automatic compare_outputs();
    chk("go", 64'(go_o), 64'(m_go));
    chk("ref_req", 64'(ref_req_o), 64'(m_ref_req));
    chk("level", 64'(level_o), 64'(m_q.size()));
    chk("ready", 64'(req_ready_o), 64'(m_q.size() != DEPTH));
    chk("go_ref_excl", 64'(go_o & ref_req_o), 64'(0));
    if (m_go || m_wait) begin
      chk("rw_en", 64'(rw_en_o), 64'(m_q[0].we));
      chk("addr", 64'(addr_o), 64'(m_q[0].addr));
      if (m_q[0].we) chk("wdata", 64'(wdata_o), 64'(m_q[0].wdata));
    end
  endtask

  // Drive inputs for the coming rising edge and advance the model across it.
  task automatic drive_and_model(input bit v, input bit we, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input bit ack, input bit rack);
    bit   idle, push, pop, nxt_go, nxt_wait, nxt_ref;
    req_t r;
    req_valid_i = v;
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = d;
    cmd_ack_i   = ack;
    ref_ack_i   = rack;

    idle     = !m_go && !m_wait && !m_ref_req;
    push     = v && (m_q.size() != DEPTH);
    pop      = m_wait && ack;
    nxt_go   = idle && !m_pend && (m_q.size() != 0);
    nxt_wait = m_go || (m_wait && !ack);
`ifdef SDRAM_SCHED_REF_EN
    nxt_ref = (idle && m_pend) || (m_ref_req && !rack);
    if (m_cnt == REF_IV - 1) begin
      m_pend = 1'b1;
      m_cnt  = 0;
    end else begin
      if (m_ref_req && rack) m_pend = 1'b0;
      m_cnt = m_cnt + 1;
    end
`else
    nxt_ref = 1'b0;
`endif
    if (pop) void'(m_q.pop_front());
    if (push) begin
      r.we = we; r.addr = a; r.wdata = d;
      m_q.push_back(r);
    end
    m_go      = nxt_go;
    m_wait    = nxt_wait;
    m_ref_req = nxt_ref;
  endtask

  task automatic step(input bit v, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit ack, input bit rack);
    @(negedge clk);
    compare_outputs();
    drive_and_model(v, we, a, d, ack, rack);
  endtask

  task automatic idle_step(input bit ack, input bit rack);
    step(1'b0, 1'b0, '0, '0, ack, rack);
  endtask

  task automatic rand_step(input int unsigned p_valid, input int unsigned p_ack);
    step($urandom_range(99) < p_valid, 1'($urandom), AW'($urandom), DW'($urandom),
         $urandom_range(99) < p_ack, $urandom_range(99) < 30);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    compare_outputs();
    drive_and_model(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values();
    chk("rst_go", 64'(go_o), 64'(0));
    chk("rst_ref_req", 64'(ref_req_o), 64'(0));
    chk("rst_level", 64'(level_o), 64'(0));
    chk("rst_rw_en", 64'(rw_en_o), 64'(0));
    chk("rst_addr", 64'(addr_o), 64'(0));
    chk("rst_wdata", 64'(wdata_o), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    cmd_ack_i   = 1'b0;
    ref_ack_i   = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_values();
    release_reset();

    // Single write: go two cycles after acceptance, outputs held until ack.
    repeat (3) idle_step(1'b0, 1'b0);
    step(1'b1, 1'b1, 24'h000123, 16'hBEEF, 1'b0, 1'b0);
    repeat (6) idle_step(1'b0, 1'b0);
    idle_step(1'b1, 1'b1);
    repeat (4) idle_step(1'b0, 1'b1);

    // Fill to full with no acks, push into full, then one ack.
    for (int i = 0; i < DEPTH + 2; i++)
      step(1'b1, i[0], AW'(24'h100 + i), DW'(16'hA000 + i), 1'b0, 1'b0);
    repeat (3) idle_step(1'b0, 1'b0);
    idle_step(1'b1, 1'b0);
    repeat (3) idle_step(1'b0, 1'b1);

    // Alternating read/write stream through several pointer wraps.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i[0], AW'(24'h200 + i), DW'(16'h5000 + i), 1'b0, 1'b1);
      repeat (2) idle_step(1'b0, 1'b1);
      idle_step(1'b1, 1'b1);
    end
    repeat (40) idle_step(1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) rand_step(60, 40);
    for (int i = 0; i < 300; i++) rand_step(0, 50);
    for (int i = 0; i < 500; i++) rand_step(90, 70);

    // Reset while waiting for an ack with entries queued.
    repeat (30) idle_step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, AW'(24'h300 + i), DW'(16'h7700 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20 && !m_wait; i++) idle_step(1'b0, 1'b1);
    #2;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    cmd_ack_i   = 1'b0;
    ref_ack_i   = 1'b0;
    #1;
    check_reset_values();
    chk("rst_ready", 64'(req_ready_o), 64'(1));
    repeat (2) @(negedge clk);
    release_reset();
    repeat (20) idle_step(1'b1, 1'b1);

    // Push after a long quiet period still issues two cycles later.
    step(1'b1, 1'b0, 24'hABCDEF, 16'h1234, 1'b0, 1'b1);
    repeat (5) idle_step(1'b0, 1'b1);
    idle_step(1'b1, 1'b1);
    repeat (30) rand_step(50, 50);
    @(negedge clk);
    compare_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
